// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Runs one calculator operation on the shared arithmetic engine. While the
// control unit holds enable high, the block collects operand A (and operand B
// for binary ops) from the switch bus. Each operand is confirmed by a next
// pulse. The block then fires a one-cycle engine start, waits for the engine's
// done, and holds the result for display until the user presses next again.
//
// Handshake semantics: eng_start is a single-cycle request. eng_result and
// eng_err are taken only in the cycle eng_done is high while in WAIT. Towards
// the control unit, done is a level that is high only in SHOW, and the control
// unit treats done && next in one cycle as completion.
//
// Optional build macro: SEQ_WATCHDOG_EN enables a WAIT watchdog. After
// MAX_WAIT WAIT cycles with no eng_done, the block goes to SHOW with err = 1
// and result = all ones.
//
// Ports:
//   Clk, Reset_n            clock; asynchronous active-low reset
//   enable                  high while the control unit is in an op state
//   op[2:0]                 operation code (7 is reserved and raises an error)
//   data_in[DATA_W-1:0]     switch bus
//   next                    one-cycle debounced button pulse
//   eng_start/op/a/b        engine request (start, latched op and operands)
//   eng_done/result/err     engine completion, result and error
//   num1_out/num2_out       operands for the displays (live while being entered)
//   result[2*DATA_W-1:0]    latched result
//   phase[2:0]              current state code (IDLE 0 .. SHOW 5)
//   done                    high only in SHOW
//   err                     latched error flag
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  enable,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  next,
    output logic                  eng_start,
    output logic [2:0]            eng_op,
    output logic [DATA_W-1:0]     eng_a,
    output logic [DATA_W-1:0]     eng_b,
    input  logic                  eng_done,
    input  logic [2*DATA_W-1:0]   eng_result,
    input  logic                  eng_err,
    output logic [DATA_W-1:0]     num1_out,
    output logic [DATA_W-1:0]     num2_out,
    output logic [2*DATA_W-1:0]   result,
    output logic [2:0]            phase,
    output logic                  done,
    output logic                  err
);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("calc_op_sequencer: MAX_WAIT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SHOW  = 3'd5
    } state_t;

    state_t                state, state_nxt;
    logic [2:0]            op_r, op_r_nxt;
    logic [DATA_W-1:0]     num1, num1_nxt;
    logic [DATA_W-1:0]     num2, num2_nxt;
    logic [2*DATA_W-1:0]   result_r, result_nxt;
    logic                  err_r, err_nxt;
    logic                  eng_active;

`ifdef SEQ_WATCHDOG_EN
    localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    // The counter holds the number of WAIT cycles already spent. So the last
    // allowed WAIT cycle is the one where it reads MAX_WAIT-1.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_WAIT - 1);
    logic [CNT_W-1:0]      wd_cnt, wd_nxt;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            op_r     <= '0;
            num1     <= '0;
            num2     <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt   <= '0;
`endif
        end else begin
            state    <= state_nxt;
            op_r     <= op_r_nxt;
            num1     <= num1_nxt;
            num2     <= num2_nxt;
            result_r <= result_nxt;
            err_r    <= err_nxt;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt   <= wd_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        op_r_nxt   = op_r;
        num1_nxt   = num1;
        num2_nxt   = num2;
        result_nxt = result_r;
        err_nxt    = err_r;
`ifdef SEQ_WATCHDOG_EN
        // The counter is zero outside WAIT, so every entry into WAIT starts at 0.
        wd_nxt     = (state == S_WAIT) ? wd_cnt + CNT_W'(1) : '0;
`endif

        // Abort has priority over everything, including a same-cycle next or
        // eng_done. Latched values are kept for display until the next op starts.
        if (state != S_IDLE && !enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        op_r_nxt   = op;
                        num1_nxt   = '0;
                        num2_nxt   = '0;
                        result_nxt = '0;
                        err_nxt    = 1'b0;
                        if (op == 3'd7) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_SHOW;
                        end else begin
                            state_nxt = S_GET_A;
                        end
                    end
                end
                S_GET_A: begin
                    if (next) begin
                        num1_nxt  = data_in;
                        // isprime and sqrt are unary, so operand B stays 0.
                        state_nxt = (op_r >= 3'd5) ? S_START : S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (next) begin
                        num2_nxt  = data_in;
                        state_nxt = S_START;
                    end
                end
                S_START: state_nxt = S_WAIT;
                S_WAIT: begin
                    if (eng_done) begin
                        result_nxt = eng_result;
                        err_nxt    = eng_err;
                        state_nxt  = S_SHOW;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        result_nxt = '1;
                        err_nxt    = 1'b1;
                        state_nxt  = S_SHOW;
                    end
`endif
                end
                S_SHOW: begin
                    if (next) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // The engine interface carries the operands only while a request is in flight.
    assign eng_active = (state == S_START) || (state == S_WAIT);
    assign eng_start  = (state == S_START);
    assign eng_op     = eng_active ? op_r : 3'd0;
    assign eng_a      = eng_active ? num1 : '0;
    assign eng_b      = eng_active ? num2 : '0;

    // While an operand is being entered, the display follows the switches.
    assign num1_out   = (state == S_GET_A) ? data_in : num1;
    assign num2_out   = (state == S_GET_B) ? data_in : num2;
    assign result     = result_r;
    assign err        = err_r;
    assign done       = (state == S_SHOW);
    assign phase      = state;

endmodule

// File: tb/tb_calc_op_sequencer.sv
module tb_calc_op_sequencer;

  localparam int W = 8;
`ifdef SEQ_WATCHDOG_EN
  localparam int TB_MAX_WAIT = 4;
`else
  localparam int TB_MAX_WAIT = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           enable = 1'b0;
  logic [2:0]     op = '0;
  logic [W-1:0]   data_in = '0;
  logic           next = 1'b0;
  logic           eng_start;
  logic [2:0]     eng_op;
  logic [W-1:0]   eng_a, eng_b;
  logic           eng_done = 1'b0;
  logic [2*W-1:0] eng_result = '0;
  logic           eng_err = 1'b0;
  logic [W-1:0]   num1_out, num2_out;
  logic [2*W-1:0] result;
  logic [2:0]     phase;
  logic           done, err;

  calc_op_sequencer #(.DATA_W(W), .MAX_WAIT(TB_MAX_WAIT)) dut (
    .Clk(clk), .Reset_n(rst_n), .enable(enable), .op(op), .data_in(data_in),
    .next(next), .eng_start(eng_start), .eng_op(eng_op), .eng_a(eng_a),
    .eng_b(eng_b), .eng_done(eng_done), .eng_result(eng_result),
    .eng_err(eng_err), .num1_out(num1_out), .num2_out(num2_out),
    .result(result), .phase(phase), .done(done), .err(err)
  );

  // ---------------- scoreboard counters ----------------
  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- engine emulator ----------------
  bit             rand_mode = 1'b0;
  int             cfg_lat = 1;        // 0 means the engine never answers
  logic [2*W-1:0] cfg_res = '0;
  logic           cfg_err = 1'b0;
  int             e_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = rand_mode ? 16'($urandom) : cfg_res;
          eng_err    = rand_mode ? ($urandom_range(0, 3) == 0) : cfg_err;
        end
      end else if (rand_mode && $urandom_range(0, 19) == 0) begin
        // stray completion pulses, which must be ignored outside WAIT
        eng_done   = 1'b1;
        eng_result = 16'($urandom);
        eng_err    = $urandom_range(0, 1) == 1;
      end
      if (eng_start) e_cnt = cfg_lat;
    end
  end

  // ---------------- behavioural reference model ----------------
  // Phase codes are the published ones: 0 idle, 1 get A, 2 get B, 3 start,
  // 4 wait, 5 show.
  int             m_ph;
  logic [2:0]     m_op;
  logic [W-1:0]   m_n1, m_n2;
  logic [2*W-1:0] m_res;
  logic           m_err;
  int             m_waited;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_op <= '0; m_n1 <= '0; m_n2 <= '0; m_res <= '0; m_err <= 1'b0;
      m_waited <= 0;
    end else if (m_ph != 0 && !enable) begin
      m_ph <= 0;
    end else begin
      case (m_ph)
        0: if (enable) begin
             m_op <= op; m_n1 <= '0; m_n2 <= '0; m_res <= '0;
             m_err <= (op == 3'd7);
             m_ph  <= (op == 3'd7) ? 5 : 1;
           end
        1: if (next) begin
             m_n1 <= data_in;
             m_ph <= (m_op == 3'd5 || m_op == 3'd6) ? 3 : 2;
           end
        2: if (next) begin m_n2 <= data_in; m_ph <= 3; end
        3: begin m_ph <= 4; m_waited <= 0; end
        4: begin
             m_waited <= m_waited + 1;
             if (eng_done) begin
               m_res <= eng_result; m_err <= eng_err; m_ph <= 5;
             end
`ifdef SEQ_WATCHDOG_EN
             else if (m_waited + 1 == TB_MAX_WAIT) begin
               m_res <= '1; m_err <= 1'b1; m_ph <= 5;
             end
`endif
           end
        5: if (next) m_ph <= 0;
        default: m_ph <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      if (eng_start) start_cnt++;
      chk("phase", 32'(phase), 32'(m_ph));
      chk("done", 32'(done), 32'(m_ph == 5));
      chk("eng_start", 32'(eng_start), 32'(m_ph == 3));
      chk("eng_op", 32'(eng_op), 32'((m_ph == 3 || m_ph == 4) ? m_op : 3'd0));
      chk("eng_a", 32'(eng_a), 32'((m_ph == 3 || m_ph == 4) ? m_n1 : 8'd0));
      chk("eng_b", 32'(eng_b), 32'((m_ph == 3 || m_ph == 4) ? m_n2 : 8'd0));
      chk("num1_out", 32'(num1_out), 32'((m_ph == 1) ? data_in : m_n1));
      chk("num2_out", 32'(num2_out), 32'((m_ph == 2) ? data_in : m_n2));
      chk("result", 32'(result), 32'(m_res));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_op();
    next = 1'b1; cyc();
    next = 1'b0; enable = 1'b0; cyc();
  endtask

  int s0;

  initial begin
    // reset
    repeat (2) cyc();
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_outs", 32'({eng_start, eng_op, done, err}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    cyc();

    // add path
    s0 = start_cnt;
    cfg_lat = 1; cfg_res = 16'h00E7; cfg_err = 1'b0;
    enable = 1'b1; op = 3'd0; cyc();
    data_in = 8'h0A; next = 1'b1; cyc();
    data_in = 8'hDD; cyc();
    next = 1'b0;
    chk("add_start", 32'(eng_start), 32'd1);
    chk("add_eng_a", 32'(eng_a), 32'h0A);
    chk("add_eng_b", 32'(eng_b), 32'hDD);
    cyc(); cyc();
    chk("add_result", 32'(result), 32'h00E7);
    chk("add_phase", 32'(phase), 32'd5);
    chk("add_done", 32'(done), 32'd1);
    chk("add_one_start", 32'(start_cnt - s0), 32'd1);
    next = 1'b1; cyc();
    next = 1'b0; enable = 1'b0;
    chk("add_back_idle", 32'({phase, done}), 32'd0);
    cyc();

    // unary path
    cfg_res = 16'h0009;
    enable = 1'b1; op = 3'd6; cyc();
    data_in = 8'h51; next = 1'b1; cyc();
    next = 1'b0;
    chk("sqrt_phase_start", 32'(phase), 32'd3);
    chk("sqrt_eng_b", 32'(eng_b), 32'd0);
    chk("sqrt_eng_a", 32'(eng_a), 32'h51);
    cyc(); cyc();
    chk("sqrt_result", 32'(result), 32'h0009);
    finish_op();

    // error path, then a fresh op clears err
    cfg_res = 16'h0000; cfg_err = 1'b1;
    enable = 1'b1; op = 3'd2; cyc();
    data_in = 8'h10; next = 1'b1; cyc();
    data_in = 8'h00; cyc();
    next = 1'b0; cyc(); cyc();
    chk("div0_err", 32'({done, err}), 32'b11);
    next = 1'b1; cyc();
    next = 1'b0; op = 3'd0; cfg_err = 1'b0; cyc();
    chk("err_cleared", 32'({phase, err}), 32'({3'd1, 1'b0}));
    enable = 1'b0; cyc();

    // abort in WAIT; the late engine done is ignored
    cfg_lat = 4;
    enable = 1'b1; op = 3'd1; cyc();
    next = 1'b1; cyc(); cyc();
    next = 1'b0; cyc();
    chk("abort_in_wait", 32'(phase), 32'd4);
    enable = 1'b0; cyc();
    chk("abort_idle", 32'(phase), 32'd0);
    repeat (6) cyc();
    chk("abort_no_done", 32'({phase, done}), 32'd0);

    // reserved op
    s0 = start_cnt;
    enable = 1'b1; op = 3'd7; cyc();
    chk("rsv_phase", 32'(phase), 32'd5);
    chk("rsv_err_res", 32'({err, result}), 32'h10000);
    finish_op();
    chk("rsv_no_start", 32'(start_cnt - s0), 32'd0);

    // next during WAIT is ignored
    cfg_lat = 3; cfg_res = 16'h1234;
    enable = 1'b1; op = 3'd0; cyc();
    next = 1'b1; cyc(); cyc(); cyc(); cyc();
    chk("wait_ignores_next", 32'(phase), 32'd4);
    next = 1'b0; cyc(); cyc();
    chk("wait_result", 32'({phase, result}), 32'({3'd5, 16'h1234}));
    finish_op();

    // asynchronous reset in the middle of GET_B
    enable = 1'b1; op = 3'd0; cyc();
    data_in = 8'h33; next = 1'b1; cyc();
    next = 1'b0;
    chk("pre_reset_getb", 32'(phase), 32'd2);
    #5 rst_n = 1'b0;
    #1;
    chk("arst_phase", 32'(phase), 32'd0);
    chk("arst_nums", 32'({num1_out, num2_out}), 32'd0);
    chk("arst_res_err", 32'({result, err, done, eng_start}), 32'd0);
    #2 rst_n = 1'b1;
    enable = 1'b0; cyc();

`ifdef SEQ_WATCHDOG_EN
    // watchdog with a silent engine
    cfg_lat = 0;
    enable = 1'b1; op = 3'd0; cyc();
    next = 1'b1; cyc(); cyc();
    next = 1'b0;
    repeat (4) cyc();
    chk("wd_still_wait", 32'(phase), 32'd4);
    cyc();
    chk("wd_timeout", 32'({phase, err, result}), 32'({3'd5, 1'b1, 16'hFFFF}));
    finish_op();
`endif

    // randomized traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      enable  = $urandom_range(0, 29) != 0;
      op      = 3'($urandom_range(0, 7));
      data_in = 8'($urandom);
      next    = $urandom_range(0, 2) == 0;
      cfg_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      cyc();
    end
    rand_mode = 1'b0;
    enable = 1'b0; next = 1'b0;
    repeat (8) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
